// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the LCD character buffer and its arbiter.
//   LCD_LINES / LCD_COLS : geometry of the character display (2 x 16)
//   BLANK_CHAR           : ASCII space, used to fill cleared cells
//   lcd_text_t           : display array, indexed [line][col] -> 8-bit char
//   arb_state_t          : arbiter FSM states
//   blank_text()         : an all-blank display array
//   max_int()            : larger of two integers, for sizing counters
package lcd_pkg;

   localparam int LCD_LINES = 2;
   localparam int LCD_COLS  = 16;
   localparam logic [7:0] BLANK_CHAR = 8'h20;

   typedef logic [LCD_LINES-1:0][LCD_COLS-1:0][7:0] lcd_text_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DWELL = 2'd2
   } arb_state_t;

   function automatic lcd_text_t blank_text();
      lcd_text_t t;
      for (int l = 0; l < LCD_LINES; l++) begin
         for (int c = 0; c < LCD_COLS; c++) begin
            t[l][c] = BLANK_CHAR;
         end
      end
      return t;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req        in  N  request vector
//   ptr        in  3  index where the search starts (must be < N)
//   sel_onehot out N  one-hot of the chosen requester (0 if none)
//   sel_idx    out 3  index of the chosen requester
//   sel_valid  out 1  at least one request was present
module rr_arbiter
   import lcd_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  logic [2:0]   ptr,
   output logic [N-1:0] sel_onehot,
   output logic [2:0]   sel_idx,
   output logic         sel_valid
);

   logic [2*N-1:0] dbl_s;
   logic [N-1:0]   rot_s;
   logic [3:0]     off_s;
   logic [3:0]     sum_s;
   logic [3:0]     wrap_s;

   // Rotate the request vector so bit 0 is the start index, take the lowest
   // set bit, then map the offset back to an absolute index.
   always_comb begin
      dbl_s     = {req, req};
      rot_s     = N'(dbl_s >> ptr);
      off_s     = 4'd0;
      sel_valid = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot_s[k]) begin
            off_s     = 4'(k);
            sel_valid = 1'b1;
         end else begin
            off_s     = off_s;
         end
      end
      sum_s = {1'b0, ptr} + off_s;
      if (sum_s >= 4'(N)) begin
         wrap_s = sum_s - 4'(N);
      end else begin
         wrap_s = sum_s;
      end
      sel_idx = wrap_s[2:0];
      if (sel_valid) begin
         sel_onehot = {{(N-1){1'b0}}, 1'b1} << wrap_s;
      end else begin
         sel_onehot = '0;
      end
   end

endmodule

// File: rtl/lcd_buffer_arbiter.sv
// lcd_buffer_arbiter: owns the 2x16 LCD character array and shares it between
// N_REQ requesters with round-robin, burst-locked grants, a post-burst dwell
// so text stays readable, and a stall watchdog.
//   CLOCK_50    in   system clock
//   Reset_n     in   synchronous active-low reset
//   Req         in   per-requester access request (level)
//   Wr_Valid    in   per-requester write strobe (owner only)
//   Wr_Line     in   per-requester target line
//   Wr_Col      in   per-requester target column
//   Wr_Char     in   per-requester character
//   Wr_Clear    in   per-requester clear-all strobe (owner only)
//   Wr_Last     in   last write of a burst, qualified by Wr_Valid
//   Grant       out  one-hot grant
//   Owner       out  current / most recent owner index
//   Busy        out  high while granted or dwelling
//   Timeout_Err out  one-cycle pulse on watchdog revoke
//   characters  out  display array [line][col]
module lcd_buffer_arbiter
   import lcd_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int DWELL_CYCLES   = 50000000,
   parameter int TIMEOUT_CYCLES = 5000000
) (
   input  logic                        CLOCK_50,
   input  logic                        Reset_n,
   input  logic [N_REQ-1:0]            Req,
   input  logic [N_REQ-1:0]            Wr_Valid,
   input  logic [N_REQ-1:0]            Wr_Line,
   input  logic [N_REQ-1:0][3:0]       Wr_Col,
   input  logic [N_REQ-1:0][7:0]       Wr_Char,
   input  logic [N_REQ-1:0]            Wr_Clear,
   input  logic [N_REQ-1:0]            Wr_Last,
   output logic [N_REQ-1:0]            Grant,
   output logic [2:0]                  Owner,
   output logic                        Busy,
   output logic                        Timeout_Err,
   output logic [1:0][15:0][7:0]       characters
);

   localparam int CNT_MAX = max_int(DWELL_CYCLES, TIMEOUT_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam bit HAS_DWELL = (DWELL_CYCLES > 0);
   localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(HAS_DWELL ? DWELL_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   arb_state_t       state_r;
   logic [N_REQ-1:0] grant_r;
   logic [2:0]       owner_r;
   logic [2:0]       ptr_r;
   logic             busy_r;
   logic             terr_r;
   logic             wrote_r;
   logic [CNT_W-1:0] stall_r;
   logic [CNT_W-1:0] dwell_r;
   lcd_text_t        chars_r;

   logic [N_REQ-1:0] arb_onehot_s;
   logic [2:0]       arb_idx_s;
   logic             arb_valid_s;
   logic [2:0]       next_ptr_s;

   logic             own_req_s;
   logic             own_valid_s;
   logic             own_line_s;
   logic [3:0]       own_col_s;
   logic [7:0]       own_char_s;
   logic             own_clear_s;
   logic             own_last_s;
   logic             activity_s;

   rr_arbiter #(.N(N_REQ)) u_rr (
      .req        (Req),
      .ptr        (ptr_r),
      .sel_onehot (arb_onehot_s),
      .sel_idx    (arb_idx_s),
      .sel_valid  (arb_valid_s)
   );

   // Next search start: one past the newly selected requester, wrapping.
   always_comb begin
      if (arb_idx_s == 3'(N_REQ - 1)) begin
         next_ptr_s = 3'd0;
      end else begin
         next_ptr_s = arb_idx_s + 3'd1;
      end
   end

   // Select the current owner's inputs; everyone else is ignored.
   always_comb begin
      own_req_s   = 1'b0;
      own_valid_s = 1'b0;
      own_line_s  = 1'b0;
      own_col_s   = 4'd0;
      own_char_s  = 8'd0;
      own_clear_s = 1'b0;
      own_last_s  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (owner_r == 3'(i)) begin
            own_req_s   = Req[i];
            own_valid_s = Wr_Valid[i];
            own_line_s  = Wr_Line[i];
            own_col_s   = Wr_Col[i];
            own_char_s  = Wr_Char[i];
            own_clear_s = Wr_Clear[i];
            own_last_s  = Wr_Last[i];
         end else begin
            own_req_s = own_req_s;
         end
      end
      activity_s = own_valid_s | own_clear_s;
   end

   // Arbiter FSM, display array and all registered outputs.
   always_ff @(posedge CLOCK_50) begin
      if (!Reset_n) begin
         state_r <= IDLE;
         grant_r <= '0;
         owner_r <= 3'd0;
         ptr_r   <= 3'd0;
         busy_r  <= 1'b0;
         terr_r  <= 1'b0;
         wrote_r <= 1'b0;
         stall_r <= '0;
         dwell_r <= '0;
         chars_r <= blank_text();
      end else begin
         terr_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (arb_valid_s) begin
                  grant_r <= arb_onehot_s;
                  owner_r <= arb_idx_s;
                  ptr_r   <= next_ptr_s;
                  state_r <= GRANT;
                  busy_r  <= 1'b1;
                  stall_r <= '0;
                  wrote_r <= 1'b0;
               end else begin
                  grant_r <= '0;
               end
            end
            GRANT: begin
               // Clear first; the later per-cell assignment wins on that cell.
               if (own_clear_s) begin
                  chars_r <= blank_text();
               end else begin
                  chars_r <= chars_r;
               end
               if (own_valid_s) begin
                  chars_r[own_line_s][own_col_s] <= own_char_s;
               end else begin
                  stall_r <= stall_r;
               end
               if (activity_s) begin
                  stall_r <= '0;
                  wrote_r <= 1'b1;
               end else begin
                  stall_r <= stall_r + 1'b1;
               end
               if (own_valid_s && own_last_s) begin
                  grant_r <= '0;
                  if (HAS_DWELL) begin
                     state_r <= DWELL;
                     dwell_r <= DWELL_LOAD;
                  end else begin
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
                  end
               end else if (!own_req_s) begin
                  grant_r <= '0;
                  // Only a requester that actually changed the text earns a dwell.
                  if (HAS_DWELL && (wrote_r || activity_s)) begin
                     state_r <= DWELL;
                     dwell_r <= DWELL_LOAD;
                  end else begin
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
                  end
               end else if (!activity_s && (stall_r == STALL_LIMIT)) begin
                  grant_r <= '0;
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
                  terr_r  <= 1'b1;
               end else begin
                  state_r <= GRANT;
               end
            end
            DWELL: begin
               grant_r <= '0;
               if (dwell_r == '0) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  dwell_r <= dwell_r - 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               grant_r <= '0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign Grant       = grant_r;
   assign Owner       = owner_r;
   assign Busy        = busy_r;
   assign Timeout_Err = terr_r;
   assign characters  = chars_r;

endmodule

// File: tb/tb_lcd_buffer_arbiter.sv
// Self-checking bench for lcd_buffer_arbiter (N_REQ=4, DWELL=4, TIMEOUT=8).
module tb_lcd_buffer_arbiter;

   localparam int N  = 4;
   localparam int DW = 4;
   localparam int TO = 8;

   logic                 clk;
   logic                 rst_n;
   logic [N-1:0]         req;
   logic [N-1:0]         wr_valid;
   logic [N-1:0]         wr_line;
   logic [N-1:0][3:0]    wr_col;
   logic [N-1:0][7:0]    wr_char;
   logic [N-1:0]         wr_clear;
   logic [N-1:0]         wr_last;
   logic [N-1:0]         grant;
   logic [2:0]           owner;
   logic                 busy;
   logic                 terr;
   logic [1:0][15:0][7:0] characters;

   int errors = 0;
   int checks = 0;

   lcd_buffer_arbiter #(.N_REQ(N), .DWELL_CYCLES(DW), .TIMEOUT_CYCLES(TO)) dut (
      .CLOCK_50    (clk),
      .Reset_n     (rst_n),
      .Req         (req),
      .Wr_Valid    (wr_valid),
      .Wr_Line     (wr_line),
      .Wr_Col      (wr_col),
      .Wr_Char     (wr_char),
      .Wr_Clear    (wr_clear),
      .Wr_Last     (wr_last),
      .Grant       (grant),
      .Owner       (owner),
      .Busy        (busy),
      .Timeout_Err (terr),
      .characters  (characters)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural model ----------------
   logic [7:0] m_chars [2][16];
   int  m_owner   = 0;
   bit  m_granted = 0;
   int  m_dwell   = 0;   // Busy cycles still to spend before arbitrating again
   int  m_quiet   = 0;   // consecutive granted cycles without activity
   bit  m_wrote   = 0;
   bit  m_terr    = 0;
   int  m_start   = 0;   // where the next round-robin search begins

   task automatic model_blank();
      for (int l = 0; l < 2; l++)
         for (int c = 0; c < 16; c++)
            m_chars[l][c] = 8'h20;
   endtask

   task automatic model_step();
      int o;
      bit act;
      m_terr = 0;
      if (!rst_n) begin
         model_blank();
         m_owner = 0; m_granted = 0; m_dwell = 0; m_quiet = 0;
         m_wrote = 0; m_start = 0;
      end else if (m_granted) begin
         o   = m_owner;
         act = wr_valid[o] || wr_clear[o];
         if (wr_clear[o]) model_blank();
         if (wr_valid[o]) m_chars[wr_line[o]][wr_col[o]] = wr_char[o];
         if (act) begin m_wrote = 1; m_quiet = 0; end
         if (wr_valid[o] && wr_last[o]) begin
            m_granted = 0; m_dwell = DW;
         end else if (!req[o]) begin
            m_granted = 0; m_dwell = m_wrote ? DW : 0;
         end else if (!act) begin
            m_quiet++;
            if (m_quiet >= TO) begin m_granted = 0; m_dwell = 0; m_terr = 1; end
         end
      end else if (m_dwell > 0) begin
         m_dwell--;
      end else begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_start + k) % N;
            if (req[idx]) begin
               m_granted = 1; m_owner = idx; m_start = (idx + 1) % N;
               m_quiet = 0; m_wrote = 0;
               break;
            end
         end
      end
   endtask

   initial model_blank();

   always @(posedge clk) model_step();

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic [N-1:0] eg;
      int bad_l, bad_c;
      eg = m_granted ? (4'b0001 << m_owner) : 4'b0000;
      checks++;
      if (grant !== eg) begin errors++; $display("FAIL model_grant t=%0t got %b expected %b", $time, grant, eg); end
      checks++;
      if (owner !== 3'(m_owner)) begin errors++; $display("FAIL model_owner t=%0t got %0d expected %0d", $time, owner, m_owner); end
      checks++;
      if (busy !== (m_granted || m_dwell > 0)) begin errors++; $display("FAIL model_busy t=%0t got %b expected %b", $time, busy, (m_granted || m_dwell > 0)); end
      checks++;
      if (terr !== m_terr) begin errors++; $display("FAIL model_terr t=%0t got %b expected %b", $time, terr, m_terr); end
      bad_l = -1; bad_c = -1;
      for (int l = 0; l < 2; l++)
         for (int c = 0; c < 16; c++)
            if (bad_l < 0 && characters[l][c] !== m_chars[l][c]) begin bad_l = l; bad_c = c; end
      checks++;
      if (bad_l >= 0) begin
         errors++;
         $display("FAIL model_chars t=%0t cell[%0d][%0d] got %h expected %h", $time, bad_l, bad_c,
                  characters[bad_l][bad_c], m_chars[bad_l][bad_c]);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_valid = '0; wr_clear = '0; wr_last = '0;
   endtask

   task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_write(input int r, input bit line, input int col, input logic [7:0] ch,
                              input bit last, input bit clr);
      idle_inputs();
      wr_valid[r] = 1'b1;
      wr_line[r]  = line;
      wr_col[r]   = 4'(col);
      wr_char[r]  = ch;
      wr_last[r]  = last;
      wr_clear[r] = clr;
   endtask

   task automatic wait_grant();
      for (int w = 0; w < 20 && grant == '0; w++) tick();
   endtask

   int n;
   int order [4] = '{3, 0, 1, 2};

   initial begin
      rst_n = 1'b0; req = '0; wr_line = '0; wr_col = '0; wr_char = '0;
      idle_inputs();
      tick(); tick();

      // reset state
      pin("reset_grant", grant, 32'h0);
      pin("reset_c00", characters[0][0], 32'h20);
      pin("reset_c115", characters[1][15], 32'h20);

      // first grant, one cycle latency
      rst_n = 1'b1; req = 4'b0100;
      tick();
      pin("first_grant", grant, 32'h4);
      pin("first_owner", owner, 32'd2);
      pin("first_busy", busy, 32'd1);

      // burst by owner 2
      drive_write(2, 1'b1, 15, 8'h41, 1'b0, 1'b0);
      tick();
      drive_write(2, 1'b0, 0, 8'h42, 1'b1, 1'b0);
      tick();
      idle_inputs(); req = 4'b1111;
      pin("burst_c115", characters[1][15], 32'h41);
      pin("burst_c00", characters[0][0], 32'h42);
      pin("burst_grant_drop", grant, 32'h0);
      pin("burst_busy", busy, 32'd1);
      // count dwell cycles (Busy high, Grant low) until the next grant
      n = 1;
      for (int w = 0; w < 20; w++) begin
         tick();
         if (grant != '0) break;
         if (busy) n++;
      end
      pin("dwell_len", n, 32'd4);

      // round robin 3,0,1,2
      for (int k = 0; k < 4; k++) begin
         wait_grant();
         pin("rr_grant", grant, 32'(4'b0001 << order[k]));
         drive_write(order[k], 1'b1, 8 + order[k], 8'(8'h61 + order[k]), 1'b1, 1'b0);
         tick();
         idle_inputs();
      end

      // isolation: owner 3 holds the grant, requester 0 tries to write 'Z'
      wait_grant();
      pin("iso_owner", owner, 32'd3);
      drive_write(0, 1'b0, 1, 8'h5A, 1'b0, 1'b0);
      tick();
      idle_inputs();
      pin("iso_c01", characters[0][1], 32'h20);
      pin("iso_c111", characters[1][11], 32'h64);

      // clear plus write in the same cycle
      drive_write(3, 1'b0, 5, 8'h51, 1'b0, 1'b1);
      tick();
      idle_inputs();
      pin("clr_c05", characters[0][5], 32'h51);
      pin("clr_c111", characters[1][11], 32'h20);
      pin("clr_c115", characters[1][15], 32'h20);

      // watchdog: owner keeps Req high but stays quiet
      n = 0;
      while (grant != '0 && n < 30) begin n++; tick(); end
      pin("wd_len", n, 32'd8);
      pin("wd_terr", terr, 32'd1);
      pin("wd_busy", busy, 32'd0);
      pin("wd_keep", characters[0][5], 32'h51);
      req = 4'b0010;
      tick();
      pin("wd_terr_pulse", terr, 32'd0);
      pin("wd_next", grant, 32'h2);

      // reset in the middle of owner 1's burst
      drive_write(1, 1'b0, 3, 8'h58, 1'b0, 1'b0);
      tick();
      idle_inputs();
      pin("mid_c03", characters[0][3], 32'h58);
      rst_n = 1'b0;
      tick();
      pin("rst_c03", characters[0][3], 32'h20);
      pin("rst_c05", characters[0][5], 32'h20);
      pin("rst_grant", grant, 32'h0);
      pin("rst_owner", owner, 32'd0);
      rst_n = 1'b1; req = 4'b0011;
      tick();
      pin("rst_rearb", grant, 32'h1);

      // randomized traffic against the model
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int quiet;
         quiet = ((cyc / 60) % 3 == 2) ? 1 : 0;
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            wr_valid[i] = quiet ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
            wr_line[i]  = 1'($urandom_range(0, 1));
            wr_col[i]   = 4'($urandom_range(0, 15));
            wr_char[i]  = 8'($urandom_range(8'h21, 8'h7E));
            wr_clear[i] = ($urandom_range(0, 24) == 0);
            wr_last[i]  = ($urandom_range(0, 4) == 0);
         end
         rst_n = ($urandom_range(0, 299) != 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
